c17_bist_engine: RTL and testbench

Built-in self-test engine that sits directly upstream and downstream of the c17 netlist. An LFSR generates a 5-bit stimulus vector that drives c17 inputs {N1,N2,N3,N6,N7}. After one settle cycle, the engine compacts the 2-bit response {N22,N23} into an 8-bit MISR. When the run ends, it compares the signature against a golden value and raises done/pass.

---
 rtl/c17_bist_pkg.sv | 36 +++
 rtl/c17_bist_engine_if.sv | 35 +++
 rtl/c17_misr.sv | 33 +++
 rtl/c17_bist_engine.sv | 119 +++++++++++
 tb/tb_c17_bist_engine.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/c17_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : c17_bist_pkg
// Description : Shared types, widths, polynomials and step functions for the
//               c17 BIST engine.
// Revision    : 1.0 - initial release
// ============================================================================
package c17_bist_pkg;

  localparam int PAT_W  = 5;
  localparam int RESP_W = 2;
  localparam int SIG_W  = 8;

  // Feedback taps q[4] and q[2] give x^5+x^3+1.
  localparam logic [PAT_W-1:0] LFSR_TAPS = 5'h14;
  localparam logic [SIG_W-1:0] MISR_POLY = 8'h1D;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] q);
    return {q[PAT_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0]  m,
                                                 input logic [RESP_W-1:0] r);
    return {m[SIG_W-2:0], 1'b0} ^ (m[SIG_W-1] ? MISR_POLY : '0)
           ^ {{(SIG_W-RESP_W){1'b0}}, r};
  endfunction

endpackage
`default_nettype wire

// File: rtl/c17_bist_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : c17_bist_engine_if
// Description : Control/stimulus/response bundle of the c17 BIST engine.
//               C17_BIST_ABORT_EN adds the abort request line.
// Revision    : 1.0 - initial release
// ============================================================================
interface c17_bist_engine_if;
  import c17_bist_pkg::*;

  logic              start;
  logic [SIG_W-1:0]  golden_sig;
  logic [PAT_W-1:0]  pat_out;
  logic [RESP_W-1:0] resp_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic [SIG_W-1:0]  signature;
  logic [PAT_W-1:0]  pat_count;
`ifdef C17_BIST_ABORT_EN
  logic              abort;

  modport master (output start, golden_sig, resp_in, abort,
                  input  pat_out, busy, done, pass, signature, pat_count);
  modport slave  (input  start, golden_sig, resp_in, abort,
                  output pat_out, busy, done, pass, signature, pat_count);
`else
  modport master (output start, golden_sig, resp_in,
                  input  pat_out, busy, done, pass, signature, pat_count);
  modport slave  (input  start, golden_sig, resp_in,
                  output pat_out, busy, done, pass, signature, pat_count);
`endif

endinterface
`default_nettype wire

// File: rtl/c17_misr.sv
`default_nettype none
// ============================================================================
// Module      : c17_misr
// Description : 8-bit MISR (x^8+x^4+x^3+x^2+1) compacting the c17 response.
// Revision    : 1.0 - initial release
// ============================================================================
module c17_misr
  import c17_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [RESP_W-1:0] resp,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] r_sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (clr) begin
      r_sig <= '0;
    end else if (en) begin
      r_sig <= misr_next(r_sig, resp);
    end
  end

  assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/c17_bist_engine.sv
`default_nettype none
// ============================================================================
// Module      : c17_bist_engine
// Description : LFSR stimulus + MISR compaction BIST around the c17 netlist.
//               Define C17_BIST_ABORT_EN to enable the abort request.
// Revision    : 1.0 - initial release
// ============================================================================
module c17_bist_engine
  import c17_bist_pkg::*;
#(
  parameter int               NUM_PATTERNS = 31,
  parameter logic [PAT_W-1:0] LFSR_SEED    = 5'h01
)
(
  input  logic               clk,
  input  logic               rst_n,
  c17_bist_engine_if.slave   bus
);

  localparam logic [PAT_W-1:0] c_num  = PAT_W'(NUM_PATTERNS);
  localparam logic [PAT_W-1:0] c_seed = (LFSR_SEED == '0) ? 5'h01 : LFSR_SEED;

  state_t           r_state;
  logic [PAT_W-1:0] r_lfsr;
  logic [PAT_W-1:0] r_cnt;
  logic [SIG_W-1:0] r_golden;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic             w_start_ok;
  logic             w_abort;
  logic [PAT_W-1:0] w_cnt_inc;
  logic [SIG_W-1:0] w_sig;
  logic [SIG_W-1:0] w_sig_next;

  assign w_start_ok = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_cnt_inc  = r_cnt + PAT_W'(1);
  assign w_sig_next = misr_next(w_sig, bus.resp_in);

`ifdef C17_BIST_ABORT_EN
  assign w_abort = bus.abort && ((r_state == APPLY) || (r_state == CAPTURE));
`else
  assign w_abort = 1'b0;
`endif

  c17_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_start_ok),
    .en    ((r_state == CAPTURE) && !w_abort),
    .resp  (bus.resp_in),
    .sig   (w_sig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_lfsr   <= '0;
      r_cnt    <= '0;
      r_golden <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            r_state  <= APPLY;
            r_lfsr   <= c_seed;
            r_cnt    <= '0;
            r_golden <= bus.golden_sig;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
          end
        end
        APPLY: begin
          if (w_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_lfsr  <= '0;
          end else begin
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (w_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_lfsr  <= '0;
          end else begin
            r_cnt  <= w_cnt_inc;
            r_lfsr <= lfsr_next(r_lfsr);
            // Pass compares the value the MISR takes on this same edge.
            if (w_cnt_inc == c_num) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_sig_next == r_golden);
            end else begin
              r_state <= APPLY;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.pat_out   = r_lfsr;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.signature = w_sig;
  assign bus.pat_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_c17_bist_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_c17_bist_engine
// Description : Self-checking bench for c17_bist_engine with a c17 model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_c17_bist_engine;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] exp_q[$];

  c17_bist_engine_if bif4 ();
  c17_bist_engine_if bif2 ();
  c17_bist_engine_if bif31 ();

  c17_bist_engine #(.NUM_PATTERNS(4), .LFSR_SEED(5'h01)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bif4.slave));
  c17_bist_engine #(.NUM_PATTERNS(2), .LFSR_SEED(5'h01)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bif2.slave));
  // Seed 0 must be replaced by 01.
  c17_bist_engine #(.NUM_PATTERNS(31), .LFSR_SEED(5'h00)) u_dut31 (
    .clk(clk), .rst_n(rst_n), .bus(bif31.slave));

  always #5 clk = ~clk;

  function automatic logic [1:0] c17(input logic [4:0] p);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
    {n1, n2, n3, n6, n7} = p;
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  function automatic logic [4:0] lfsr_m(input logic [4:0] q);
    return {q[3:0], q[4] ^ q[2]};
  endfunction

  function automatic logic [7:0] misr_m(input logic [7:0] m, input logic [1:0] r);
    logic [7:0] t;
    t = {m[6:0], 1'b0} ^ (m[7] ? 8'h1D : 8'h00);
    return t ^ {6'b0, r};
  endfunction

  assign bif31.resp_in = c17(bif31.pat_out);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run4(input string tag, input logic [7:0] gold, input logic [1:0] resp,
                      input logic [7:0] exp_sig, input logic exp_pass);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h09);
    bif4.golden_sig = gold;
    bif4.resp_in    = resp;
    bif4.start      = 1'b1;
    tick();
    bif4.start      = 1'b0;
    bif4.golden_sig = ~gold;
    check({tag, "_busy_rise"}, bif4.busy, 1);
    check({tag, "_done_fall"}, bif4.done, 0);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_pat"}, bif4.pat_out, exp_q.pop_front());
      if (i == 1) bif4.start = 1'b1;
      tick();
      bif4.start = 1'b0;
      check({tag, "_busy_cap"}, bif4.busy, 1);
      check({tag, "_done_early"}, bif4.done, 0);
      tick();
      if (i < 3) check({tag, "_done_early"}, bif4.done, 0);
    end
    check({tag, "_done"}, bif4.done, 1);
    check({tag, "_busy_end"}, bif4.busy, 0);
    check({tag, "_pass"}, bif4.pass, exp_pass);
    check({tag, "_sig"}, bif4.signature, exp_sig);
    check({tag, "_count"}, bif4.pat_count, 4);
    check({tag, "_pat_hold"}, bif4.pat_out, 8'h12);
  endtask

  initial begin
    logic [7:0]  sig11;
    logic [7:0]  sig31;
    logic [4:0]  q;
    logic [31:0] seen;

    bif4.start = 1'b0;  bif4.golden_sig = '0;  bif4.resp_in = '0;
    bif2.start = 1'b0;  bif2.golden_sig = '0;  bif2.resp_in = '0;
    bif31.start = 1'b0; bif31.golden_sig = '0;
`ifdef C17_BIST_ABORT_EN
    bif4.abort = 1'b0; bif2.abort = 1'b0; bif31.abort = 1'b0;
`endif

    repeat (2) tick();
    check("rst_pat", bif4.pat_out, 0);
    check("rst_busy", bif4.busy, 0);
    check("rst_done", bif4.done, 0);
    check("rst_pass", bif4.pass, 0);
    check("rst_sig", bif4.signature, 0);
    check("rst_count", bif4.pat_count, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    sig11 = 8'h00;
    for (int i = 0; i < 4; i++) sig11 = misr_m(sig11, 2'b11);

    run4("zero_pass", 8'h00, 2'b00, 8'h00, 1'b1);
    run4("zero_fail", 8'h01, 2'b00, 8'h00, 1'b0);

    // Two-pattern run with a single non-zero response.
    bif2.golden_sig = 8'h02;
    bif2.start = 1'b1;
    tick();
    bif2.start = 1'b0;
    tick();
    bif2.resp_in = 2'b01;
    tick();
    bif2.resp_in = 2'b00;
    check("two_sig_mid", bif2.signature, 8'h01);
    tick();
    tick();
    check("two_done", bif2.done, 1);
    check("two_sig", bif2.signature, 8'h02);
    check("two_pass", bif2.pass, 1);
    check("two_count", bif2.pat_count, 2);

    // Full 31-vector run against the c17 model.
    q = 5'h01;
    sig31 = 8'h00;
    for (int i = 0; i < 31; i++) begin
      exp_q.push_back({3'b0, q});
      sig31 = misr_m(sig31, c17(q));
      q = lfsr_m(q);
    end
    bif31.golden_sig = sig31;
    bif31.start = 1'b1;
    tick();
    bif31.start = 1'b0;
    seen = '0;
    for (int i = 0; i < 31; i++) begin
      check("full_pat", bif31.pat_out, exp_q.pop_front());
      seen = seen | (32'h1 << bif31.pat_out);
      tick();
      tick();
    end
    check("full_seen", seen, 32'hFFFF_FFFE);
    check("full_done", bif31.done, 1);
    check("full_sig", bif31.signature, sig31);
    check("full_pass", bif31.pass, 1);
    check("full_count", bif31.pat_count, 31);

    // Reset during the third APPLY.
    bif4.resp_in = 2'b11;
    bif4.start = 1'b1;
    tick();
    bif4.start = 1'b0;
    repeat (4) tick();
    check("mid_sig_pre", bif4.signature, misr_m(misr_m(8'h00, 2'b11), 2'b11));
    check("mid_busy_pre", bif4.busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pat", bif4.pat_out, 0);
    check("mid_rst_busy", bif4.busy, 0);
    check("mid_rst_done", bif4.done, 0);
    check("mid_rst_pass", bif4.pass, 0);
    check("mid_rst_sig", bif4.signature, 0);
    check("mid_rst_count", bif4.pat_count, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    run4("restart", sig11, 2'b11, sig11, 1'b1);

`ifdef C17_BIST_ABORT_EN
    // Abort during the second CAPTURE.
    bif4.start = 1'b1;
    tick();
    bif4.start = 1'b0;
    repeat (3) tick();
    bif4.abort = 1'b1;
    tick();
    bif4.abort = 1'b0;
    check("abort_busy", bif4.busy, 0);
    check("abort_done", bif4.done, 0);
    check("abort_pass", bif4.pass, 0);
    check("abort_pat", bif4.pat_out, 0);
    check("abort_count", bif4.pat_count, 1);
    check("abort_sig", bif4.signature, 8'h03);
    repeat (3) tick();
    check("abort_idle_done", bif4.done, 0);
    check("abort_idle_busy", bif4.busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
